// File: rtl/spi_sclk_gen.sv
// SPI serial-clock and edge-strobe generator: one NBITS-bit frame per accepted start, four SPI modes.
// All outputs are registered. The rate is programmable per frame. Inputs are ignored mid-frame except abort.
module spi_sclk_gen #(
    parameter int DIV_W = 16,
    parameter int NBITS = 8,
    parameter int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [DIV_W-1:0] half_div,
    output logic             busy,
    output logic             sclk,
    output logic             lead_edge,
    output logic             trail_edge,
    output logic             sample_stb,
    output logic             shift_stb,
    output logic [IDX_W-1:0] bit_idx,
    output logic             done
);

    localparam int EDGE_W = $clog2(2*NBITS + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*NBITS);

    typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

    state_t             state, state_n;
    logic [DIV_W-1:0]   cnt, cnt_n, div_m1;
    logic [EDGE_W-1:0]  edge_cnt, edge_n;
    logic               cpol_l, cpha_l;
    logic               tc, toggle, latch;
    logic               sclk_n, lead_n, trail_n, sample_n, shift_n, busy_n, done_n;
    logic [IDX_W-1:0]   bit_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            edge_cnt   <= '0;
            div_m1     <= '0;
            cpol_l     <= 1'b0;
            cpha_l     <= 1'b0;
            sclk       <= 1'b0;
            lead_edge  <= 1'b0;
            trail_edge <= 1'b0;
            sample_stb <= 1'b0;
            shift_stb  <= 1'b0;
            bit_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            edge_cnt   <= edge_n;
            sclk       <= sclk_n;
            lead_edge  <= lead_n;
            trail_edge <= trail_n;
            sample_stb <= sample_n;
            shift_stb  <= shift_n;
            bit_idx    <= bit_n;
            busy       <= busy_n;
            done       <= done_n;
            if (latch) begin
                cpol_l <= cpol;
                cpha_l <= cpha;
                div_m1 <= (half_div == '0) ? '0 : half_div - DIV_W'(1);
            end
        end
    end

    assign tc    = (cnt == div_m1);
    assign latch = (state == IDLE) && start;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        edge_n  = edge_cnt;
        toggle  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    edge_n  = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (tc) begin
                    cnt_n  = '0;
                    toggle = 1'b1;
                    edge_n = edge_cnt + EDGE_W'(1);
                    if (edge_n == LAST_EDGE) state_n = TAIL;
                end else begin
                    cnt_n = cnt + DIV_W'(1);
                end
            end
            TAIL: begin
                if (abort || tc) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + DIV_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // done is registered, so it is raised when the next cycle is the tail's terminal count
    always_comb begin
        sclk_n  = sclk;
        lead_n  = 1'b0;
        trail_n = 1'b0;
        bit_n   = bit_idx;
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == TAIL) && (cnt_n == div_m1);
        case (state)
            IDLE: begin
                sclk_n = cpol;
                bit_n  = '0;
            end
            RUN: begin
                if (abort) begin
                    sclk_n = cpol_l;
                    bit_n  = '0;
                end else if (toggle) begin
                    sclk_n  = ~sclk;
                    lead_n  = edge_n[0];
                    trail_n = ~edge_n[0];
                    if (!edge_n[0] && edge_n != LAST_EDGE) bit_n = bit_idx + IDX_W'(1);
                end
            end
            TAIL: begin
                if (abort) begin
                    sclk_n = cpol_l;
                    bit_n  = '0;
                end else if (tc) begin
                    bit_n = '0;
                end
            end
            default: begin
                sclk_n = 1'b0;
                bit_n  = '0;
            end
        endcase
        sample_n = cpha_l ? trail_n : lead_n;
        shift_n  = cpha_l ? lead_n  : trail_n;
    end

endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
Parametrised SPI serial-clock and edge-strobe generator, successor to the fixed-rate 1 us divider. It produces SCLK at a runtime-programmable rate for one frame of NBITS bits, supports all four SPI modes via CPOL/CPHA, and emits one-cycle leading/trailing and sample/shift strobes. It sits between the SPI master control FSM and the shift register, with a start/busy/done handshake.

Parameters:
DIV_W, 16, width of half-period divisor input
NBITS, 8, bits per frame (≥1); frame = 2*NBITS SCLK edges
IDX_W, $clog2(NBITS) (min 1), width of bit_idx

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  frame request, sampled only in IDLE
abort  in  1  synchronous frame abort
cpol  in  1  SCLK idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
half_div  in  DIV_W  clk cycles per SCLK half-period; 0 treated as 1
busy  out  1  frame in progress
sclk  out  1  SPI serial clock
lead_edge  out  1  one-cycle pulse coincident with each leading (idle→active) SCLK transition
trail_edge  out  1  one-cycle pulse coincident with each trailing (active→idle) transition
sample_stb  out  1  = lead_edge if cpha=0, else trail_edge
shift_stb  out  1  = trail_edge if cpha=0, else lead_edge
bit_idx  out  IDX_W  index of current bit, 0..NBITS-1
done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, rst=1): state IDLE, sclk=0, busy=0, all strobes 0, bit_idx=0, done=0, counters 0, latched mode 0.
- All outputs registered; strobes assert in the same cycle the new sclk value is visible.
- States: IDLE, RUN, TAIL.
- IDLE:
  - sclk tracks cpol with one-cycle latency.
  - start=1 latches cpol, cpha, and max(half_div,1) into internal registers; clears the half-period counter, edge counter and bit_idx; next state RUN; busy=1 from the next cycle.
  - Input changes to cpol/cpha/half_div after latching have no effect until the next start.
- RUN:
  - Half-period counter increments each cycle. When it reaches div-1, it clears, sclk toggles, and the edge counter increments.
  - Odd edges (1st, 3rd, ...) are leading and pulse lead_edge; even edges pulse trail_edge.
  - bit_idx increments on each trailing edge except the last (it holds at NBITS-1).
  - After edge 2*NBITS (sclk is back at the latched cpol), next state TAIL with the counter cleared.
- TAIL:
  - One further half-period with sclk at idle.
  - On its terminal count: done=1 for one cycle, busy=0 from the next cycle, next state IDLE, bit_idx returns to 0.
- Frame length: busy high for exactly (2*NBITS+1)*div cycles; done is high in the last busy cycle.
- start while busy (including the done cycle) is ignored. No queuing.
- abort=1 in RUN or TAIL: next cycle IDLE, sclk=latched cpol, busy=0, no strobes, no done. abort in IDLE has no effect. abort has priority over start and over any edge in the same cycle.
- rst asserted mid-frame: immediate return to reset values, with no strobe or done emitted.
- Counter width DIV_W. half_div = 2^DIV_W-1 must work without overflow. Edge counter sized to hold 2*NBITS.
- div=1: sclk toggles every cycle and strobes may be high on consecutive cycles.

Test Plan:
- Mode 0, NBITS=8, half_div=4, start pulse:
  - busy high for 68 cycles.
  - sclk is 0 idle; first rise 4 cycles after busy rises.
  - 8 lead_edge and 8 sample_stb pulses, 8 trail_edge pulses.
  - bit_idx runs 0..7.
  - exactly one done pulse, in the last busy cycle.
- Mode 3 (cpol=1, cpha=1), half_div=2:
  - sclk idles 1 and first edge falls.
  - sample_stb is coincident with the 8 rising edges; shift_stb with the falling edges.
  - busy lasts 34 cycles.
- half_div=0 and half_div=1: identical waveforms, with sclk toggling every cycle and busy for 17 cycles. half_div=65535: first edge at cycle 65535, no wrap.
- start held high continuously, half_div=3: frames separated by exactly one IDLE cycle; no start accepted while busy; done count equals frame count.
- abort after the 5th edge: busy low next cycle, sclk=cpol, no done. A following start produces a complete, correct frame.
- rst asserted mid-frame, with cpol=1 latched: sclk, busy and strobes drop to 0 asynchronously. After rst release and cpol=1, sclk returns to 1 one cycle later.
